// File: rtl/regfile_master.sv
// Command front-end for an external dual-read/single-write register file.
// Sequences write pulses and latency-aligned dual reads, returning one response per command.
module regfile_master #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr1,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              select,
  output logic [ADDR_W-1:0] readAddress1,
  output logic [ADDR_W-1:0] readAddress2,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_write,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_e;

  state_e            state_q;
  logic              cmd_ready_q;
  logic              select_q;
  logic [ADDR_W-1:0] raddr1_q;
  logic [ADDR_W-1:0] raddr2_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data1_q;
  logic [DATA_W-1:0] rsp_data2_q;
  logic              rsp_write_q;
  logic              rsp_err_q;

  logic cmd_fire;
  logic addr1_bad;
  logic addr2_bad;
  logic addr_err;

  // Writes only use addr1; reads use both.
  assign cmd_fire  = cmd_valid & cmd_ready_q;
  assign addr1_bad = 32'(cmd_addr1) >= NUM_REGS;
  assign addr2_bad = 32'(cmd_addr2) >= NUM_REGS;
  assign addr_err  = addr1_bad | (~cmd_write & addr2_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      select_q    <= 1'b1;
      raddr1_q    <= '0;
      raddr2_q    <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            if (addr_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_write_q <= 1'b0;
              rsp_data1_q <= '0;
              rsp_data2_q <= '0;
            end else if (cmd_write) begin
              state_q  <= WRITE;
              select_q <= 1'b0;
              waddr_q  <= cmd_addr1;
              wdata_q  <= cmd_wdata;
            end else begin
              state_q  <= READ_WAIT;
              raddr1_q <= cmd_addr1;
              raddr2_q <= cmd_addr2;
              cnt_q    <= CNT_W'(READ_LAT - 1);
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        WRITE: begin
          select_q <= 1'b1;
          state_q  <= RESP;
        end
        READ_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data1_q <= readData1;
            rsp_data2_q <= readData2;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          // Entry from WRITE arrives without a response; the ack is raised one cycle later.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          select_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign select       = select_q;
  assign readAddress1 = raddr1_q;
  assign readAddress2 = raddr2_q;
  assign writeAddress = waddr_q;
  assign writeData    = wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data1    = rsp_data1_q;
  assign rsp_data2    = rsp_data2_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_regfile_master.sv
// Directed bench for regfile_master: main (32 regs, lat 1), error (16 regs) and latency (lat 3) instances.
module tb_regfile_master;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  // Main instance signals
  logic        m_cv, m_cr, m_cw, m_sel, m_rv, m_rr, m_rw, m_re;
  logic [4:0]  m_a1, m_a2, m_ra1, m_ra2, m_wa;
  logic [15:0] m_wdi, m_wd, m_rd1, m_rd2, m_d1, m_d2;
  // Error instance signals
  logic        e_cv, e_cr, e_cw, e_sel, e_rv, e_rr, e_rw, e_re;
  logic [4:0]  e_a1, e_a2, e_ra1, e_ra2, e_wa;
  logic [15:0] e_wdi, e_wd, e_rd1, e_rd2, e_d1, e_d2;
  // Latency instance signals
  logic        l_cv, l_cr, l_cw, l_sel, l_rv, l_rr, l_rw, l_re;
  logic [4:0]  l_a1, l_a2, l_ra1, l_ra2, l_wa;
  logic [15:0] l_wdi, l_wd, l_rd1, l_rd2, l_d1, l_d2;

  logic [15:0] mem [32];
  logic        mem_clr;
  logic [15:0] l_p0a, l_p1a, l_p0b, l_p1b;

  regfile_master u_main (
    .clk(clk), .rst_n(rst_n), .cmd_valid(m_cv), .cmd_ready(m_cr), .cmd_write(m_cw),
    .cmd_addr1(m_a1), .cmd_addr2(m_a2), .cmd_wdata(m_wdi), .select(m_sel),
    .readAddress1(m_ra1), .readAddress2(m_ra2), .writeAddress(m_wa), .writeData(m_wd),
    .readData1(m_rd1), .readData2(m_rd2), .rsp_valid(m_rv), .rsp_ready(m_rr),
    .rsp_data1(m_d1), .rsp_data2(m_d2), .rsp_write(m_rw), .rsp_err(m_re)
  );

  regfile_master #(.NUM_REGS(16)) u_err (
    .clk(clk), .rst_n(rst_n), .cmd_valid(e_cv), .cmd_ready(e_cr), .cmd_write(e_cw),
    .cmd_addr1(e_a1), .cmd_addr2(e_a2), .cmd_wdata(e_wdi), .select(e_sel),
    .readAddress1(e_ra1), .readAddress2(e_ra2), .writeAddress(e_wa), .writeData(e_wd),
    .readData1(e_rd1), .readData2(e_rd2), .rsp_valid(e_rv), .rsp_ready(e_rr),
    .rsp_data1(e_d1), .rsp_data2(e_d2), .rsp_write(e_rw), .rsp_err(e_re)
  );

  regfile_master #(.READ_LAT(3)) u_lat (
    .clk(clk), .rst_n(rst_n), .cmd_valid(l_cv), .cmd_ready(l_cr), .cmd_write(l_cw),
    .cmd_addr1(l_a1), .cmd_addr2(l_a2), .cmd_wdata(l_wdi), .select(l_sel),
    .readAddress1(l_ra1), .readAddress2(l_ra2), .writeAddress(l_wa), .writeData(l_wd),
    .readData1(l_rd1), .readData2(l_rd2), .rsp_valid(l_rv), .rsp_ready(l_rr),
    .rsp_data1(l_d1), .rsp_data2(l_d2), .rsp_write(l_rw), .rsp_err(l_re)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32x16 register file model: write while select=0, combinational read
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0;
    end else if (!m_sel) begin
      mem[m_wa] <= m_wd;
    end
  end
  assign m_rd1 = mem[m_ra1];
  assign m_rd2 = mem[m_ra2];

  assign e_rd1 = 16'hBEEF;
  assign e_rd2 = 16'hCAFE;

  // Three-cycle register file model: data valid only after address held for three edges
  always @(posedge clk) begin
    l_p0a <= 16'h1000 + 16'(l_ra1);
    l_p1a <= l_p0a;
    l_p0b <= 16'h1000 + 16'(l_ra2);
    l_p1b <= l_p0b;
  end
  assign l_rd1 = l_p1a;
  assign l_rd2 = l_p1b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_m(input logic w, input logic [4:0] a1, input logic [4:0] a2, input logic [15:0] wd);
    m_cv = 1'b1; m_cw = w; m_a1 = a1; m_a2 = a2; m_wdi = wd;
    tick();
    m_cv = 1'b0;
  endtask

  task automatic issue_e(input logic w, input logic [4:0] a1, input logic [4:0] a2, input logic [15:0] wd);
    e_cv = 1'b1; e_cw = w; e_a1 = a1; e_a2 = a2; e_wdi = wd;
    tick();
    e_cv = 1'b0;
  endtask

  task automatic issue_l(input logic w, input logic [4:0] a1, input logic [4:0] a2, input logic [15:0] wd);
    l_cv = 1'b1; l_cw = w; l_a1 = a1; l_a2 = a2; l_wdi = wd;
    tick();
    l_cv = 1'b0;
  endtask

  task automatic ack_m();
    m_rr = 1'b1; tick(); m_rr = 1'b0;
  endtask

  task automatic ack_e();
    e_rr = 1'b1; tick(); e_rr = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (m_sel !== 1'b1) $display("FAIL reset_select got %0h want 1", m_sel); else passed++;
    total++; if (m_cr !== 1'b0) $display("FAIL reset_cmd_ready got %0h want 0", m_cr); else passed++;
    total++; if (m_rv !== 1'b0 || m_rw !== 1'b0 || m_re !== 1'b0)
      $display("FAIL reset_rsp got v%0h w%0h e%0h want 000", m_rv, m_rw, m_re); else passed++;
    total++; if (m_wa !== 5'd0 || m_wd !== 16'd0 || m_ra1 !== 5'd0 || m_d1 !== 16'd0)
      $display("FAIL reset_regs got wa%0h wd%0h ra1%0h d1%0h want 0", m_wa, m_wd, m_ra1, m_d1); else passed++;
    @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;
    tick();
    total++; if (m_cr !== 1'b1 || e_cr !== 1'b1 || l_cr !== 1'b1)
      $display("FAIL reset_release_ready got %0h%0h%0h want 111", m_cr, e_cr, l_cr); else passed++;
  endtask

  task automatic test_write();
    issue_m(1'b1, 5'd1, 5'd0, 16'd15);
    total++; if (m_sel !== 1'b0) $display("FAIL wr_select_low got %0h want 0", m_sel); else passed++;
    total++; if (m_wa !== 5'd1 || m_wd !== 16'd15)
      $display("FAIL wr_addr_data got %0d/%0d want 1/15", m_wa, m_wd); else passed++;
    total++; if (m_cr !== 1'b0 || m_rv !== 1'b0)
      $display("FAIL wr_busy got cr%0h rv%0h want 0 0", m_cr, m_rv); else passed++;
    tick();
    total++; if (m_sel !== 1'b1 || m_rv !== 1'b0)
      $display("FAIL wr_pulse_end got sel%0h rv%0h want 1 0", m_sel, m_rv); else passed++;
    tick();
    total++; if (m_rv !== 1'b1 || m_rw !== 1'b1 || m_re !== 1'b0 || m_d1 !== 16'd0)
      $display("FAIL wr_rsp got v%0h w%0h e%0h d1%0h want 1 1 0 0", m_rv, m_rw, m_re, m_d1); else passed++;
    ack_m();
    total++; if (m_rv !== 1'b0 || m_cr !== 1'b1)
      $display("FAIL wr_handshake got rv%0h cr%0h want 0 1", m_rv, m_cr); else passed++;
    total++; if (m_wa !== 5'd1 || m_wd !== 16'd15 || m_sel !== 1'b1)
      $display("FAIL wr_hold got wa%0d wd%0d sel%0h want 1 15 1", m_wa, m_wd, m_sel); else passed++;
  endtask

  task automatic test_read();
    issue_m(1'b1, 5'd3, 5'd0, 16'd10);
    tick(); tick();
    ack_m();
    issue_m(1'b0, 5'd1, 5'd3, 16'd0);
    total++; if (m_ra1 !== 5'd1 || m_ra2 !== 5'd3 || m_sel !== 1'b1 || m_rv !== 1'b0)
      $display("FAIL rd_addr got ra1%0d ra2%0d sel%0h rv%0h want 1 3 1 0", m_ra1, m_ra2, m_sel, m_rv); else passed++;
    tick();
    total++; if (m_rv !== 1'b1 || m_d1 !== 16'd15 || m_d2 !== 16'd10 || m_rw !== 1'b0 || m_re !== 1'b0)
      $display("FAIL rd_data got v%0h d1%0d d2%0d w%0h e%0h want 1 15 10 0 0", m_rv, m_d1, m_d2, m_rw, m_re); else passed++;
  endtask

  task automatic test_backpressure();
    // response from test_read is pending; offer a write that must be ignored
    m_cv = 1'b1; m_cw = 1'b1; m_a1 = 5'd7; m_wdi = 16'd99;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (m_rv !== 1'b1 || m_d1 !== 16'd15 || m_d2 !== 16'd10 || m_cr !== 1'b0 || m_sel !== 1'b1)
        $display("FAIL bp_hold%0d got v%0h d1%0d d2%0d cr%0h sel%0h want 1 15 10 0 1", k, m_rv, m_d1, m_d2, m_cr, m_sel);
      else passed++;
    end
    m_rr = 1'b1;
    tick();
    m_cv = 1'b0; m_rr = 1'b0;
    total++; if (m_rv !== 1'b0 || m_cr !== 1'b1 || m_sel !== 1'b1)
      $display("FAIL bp_release got rv%0h cr%0h sel%0h want 0 1 1", m_rv, m_cr, m_sel); else passed++;
    issue_m(1'b0, 5'd7, 5'd1, 16'd0);
    tick();
    total++; if (m_rv !== 1'b1 || m_d1 !== 16'd0 || m_d2 !== 16'd15)
      $display("FAIL bp_no_write got v%0h d1%0d d2%0d want 1 0 15", m_rv, m_d1, m_d2); else passed++;
    ack_m();
  endtask

  task automatic test_reset_mid_write();
    issue_m(1'b1, 5'd5, 5'd0, 16'h55);
    total++; if (m_sel !== 1'b0) $display("FAIL rst_wr_entered got %0h want 0", m_sel); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_sel !== 1'b1 || m_cr !== 1'b0 || m_rv !== 1'b0 || m_wa !== 5'd0)
      $display("FAIL rst_async got sel%0h cr%0h rv%0h wa%0d want 1 0 0 0", m_sel, m_cr, m_rv, m_wa); else passed++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (m_cr !== 1'b0) $display("FAIL rst_ready_early got %0h want 0", m_cr); else passed++;
    tick();
    total++; if (m_cr !== 1'b1 || m_rv !== 1'b0 || m_sel !== 1'b1)
      $display("FAIL rst_release got cr%0h rv%0h sel%0h want 1 0 1", m_cr, m_rv, m_sel); else passed++;
    issue_m(1'b0, 5'd5, 5'd1, 16'd0);
    tick();
    total++; if (m_rv !== 1'b1 || m_d1 !== 16'd0 || m_d2 !== 16'd15)
      $display("FAIL rst_no_write got v%0h d1%0h d2%0d want 1 0 15", m_rv, m_d1, m_d2); else passed++;
    ack_m();
  endtask

  task automatic test_err();
    issue_e(1'b0, 5'd20, 5'd2, 16'd0);
    total++; if (e_rv !== 1'b1 || e_re !== 1'b1 || e_d1 !== 16'd0 || e_d2 !== 16'd0)
      $display("FAIL err_rd_rsp got v%0h e%0h d1%0h d2%0h want 1 1 0 0", e_rv, e_re, e_d1, e_d2); else passed++;
    total++; if (e_sel !== 1'b1 || e_ra1 !== 5'd0)
      $display("FAIL err_rd_skip got sel%0h ra1%0d want 1 0", e_sel, e_ra1); else passed++;
    tick();
    total++; if (e_sel !== 1'b1 || e_rv !== 1'b1)
      $display("FAIL err_rd_hold got sel%0h rv%0h want 1 1", e_sel, e_rv); else passed++;
    ack_e();
    issue_e(1'b1, 5'd16, 5'd0, 16'd77);
    total++; if (e_sel !== 1'b1 || e_re !== 1'b1 || e_rv !== 1'b1 || e_wa !== 5'd0)
      $display("FAIL err_wr got sel%0h e%0h v%0h wa%0d want 1 1 1 0", e_sel, e_re, e_rv, e_wa); else passed++;
    tick();
    total++; if (e_sel !== 1'b1) $display("FAIL err_wr_sel got %0h want 1", e_sel); else passed++;
    ack_e();
    issue_e(1'b0, 5'd15, 5'd0, 16'd0);
    total++; if (e_rv !== 1'b0 || e_ra1 !== 5'd15)
      $display("FAIL err_edge_addr got v%0h ra1%0d want 0 15", e_rv, e_ra1); else passed++;
    tick();
    total++; if (e_rv !== 1'b1 || e_re !== 1'b0 || e_d1 !== 16'hBEEF || e_d2 !== 16'hCAFE)
      $display("FAIL err_edge_rsp got v%0h e%0h d1%0h d2%0h want 1 0 beef cafe", e_rv, e_re, e_d1, e_d2); else passed++;
    ack_e();
  endtask

  task automatic test_latency();
    issue_l(1'b0, 5'd5, 5'd9, 16'd0);
    total++; if (l_ra1 !== 5'd5 || l_ra2 !== 5'd9 || l_rv !== 1'b0)
      $display("FAIL lat_accept got ra1%0d ra2%0d rv%0h want 5 9 0", l_ra1, l_ra2, l_rv); else passed++;
    for (int k = 1; k <= 2; k++) begin
      tick();
      total++; if (l_ra1 !== 5'd5 || l_ra2 !== 5'd9 || l_rv !== 1'b0 || l_sel !== 1'b1)
        $display("FAIL lat_wait%0d got ra1%0d ra2%0d rv%0h sel%0h want 5 9 0 1", k, l_ra1, l_ra2, l_rv, l_sel);
      else passed++;
    end
    tick();
    total++; if (l_rv !== 1'b1 || l_d1 !== 16'h1005 || l_d2 !== 16'h1009 || l_re !== 1'b0)
      $display("FAIL lat_capture got v%0h d1%0h d2%0h e%0h want 1 1005 1009 0", l_rv, l_d1, l_d2, l_re); else passed++;
    l_rr = 1'b1; tick(); l_rr = 1'b0;
    total++; if (l_rv !== 1'b0 || l_cr !== 1'b1)
      $display("FAIL lat_handshake got rv%0h cr%0h want 0 1", l_rv, l_cr); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; mem_clr = 1'b1;
    m_cv = 0; m_cw = 0; m_a1 = 0; m_a2 = 0; m_wdi = 0; m_rr = 0;
    e_cv = 0; e_cw = 0; e_a1 = 0; e_a2 = 0; e_wdi = 0; e_rr = 0;
    l_cv = 0; l_cw = 0; l_a1 = 0; l_a2 = 0; l_wdi = 0; l_rr = 0;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_reset_mid_write();
    test_err();
    test_latency();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_master.md
REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 SHALL have parameter: DATA_W, 16, register data width.
REQ-002 SHALL have parameter: ADDR_W, 5, register address width.
REQ-003 SHALL have parameter: NUM_REGS, 32, number of implemented registers (legal addresses 0..NUM_REGS-1).
REQ-004 SHALL have parameter: READ_LAT, 1, cycles from address drive to valid readData1/readData2 (range 1..4).
REQ-005 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: cmd_valid  input  1  command offered.
REQ-008 SHALL have port: cmd_ready  output  1  command accepted when both are high.
REQ-009 SHALL have port: cmd_write  input  1  1 = write, 0 = dual read.
REQ-010 SHALL have port: cmd_addr1 / cmd_addr2  input  ADDR_W each  read addresses (cmd_addr1 is also the write address).
REQ-011 SHALL have port: cmd_wdata  input  DATA_W  write data.
REQ-012 SHALL have port: select  output  1  register-file mode, 1 = read, 0 = write.
REQ-013 SHALL have port: readAddress1 / readAddress2 / writeAddress  output  ADDR_W each  register-file addresses.
REQ-014 SHALL have port: writeData  output  DATA_W  register-file write data.
REQ-015 SHALL have port: readData1 / readData2  input  DATA_W each  register-file read data.
REQ-016 SHALL have port: rsp_valid / rsp_ready  output / input  1 each  response handshake.
REQ-017 SHALL have port: rsp_data1 / rsp_data2  output  DATA_W each  captured read data (0 for writes/errors).
REQ-018 SHALL have port: rsp_write / rsp_err  output  1 each  response is a write ack / address error.

Function
REQ-019 SHALL implement FSM states IDLE, WRITE, READ_WAIT, RESP.
REQ-020 SHALL assert cmd_ready only in IDLE; a command is accepted on a clock edge with cmd_valid&cmd_ready, with all cmd_* fields registered at that edge.
REQ-021 SHALL, on an accepted command with any used address >= NUM_REGS, skip the register file, go directly to RESP with rsp_err=1, data 0, and never drive select=0.
REQ-022 SHALL, for an accepted legal write at edge N, drive select=0, writeAddress=cmd_addr1 and writeData=cmd_wdata for exactly the one cycle following N (state WRITE), then return select=1 and enter RESP, with rsp_valid=1 and rsp_write=1 after edge N+2.
REQ-023 SHALL, for an accepted legal read at edge N, drive readAddress1/readAddress2 from edge N onward with select=1, hold them stable for READ_LAT cycles (state READ_WAIT, counter), capture readData1/readData2 at edge N+READ_LAT into rsp_data1/rsp_data2, and assert rsp_valid after that edge.
REQ-024 SHALL hold select=1 in every state except WRITE.
REQ-025 SHALL hold writeAddress/writeData stable outside WRITE at their last values.
REQ-026 SHALL hold rsp_valid and all rsp_* fields stable in RESP until rsp_ready=1; on that edge it SHALL return to IDLE (rsp_valid low, cmd_ready high the next cycle); a new command cannot be accepted in the same cycle as a response handshake.
REQ-027 SHALL treat NUM_REGS=32 with ADDR_W=5 as having no illegal addresses.
REQ-028 SHALL ignore cmd_* inputs whenever cmd_ready=0.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronously), force state IDLE, select=1, all addresses/writeData/rsp_data* 0, rsp_valid/rsp_write/rsp_err 0, cmd_ready 0; cmd_ready SHALL be 1 from the first clock edge after rst_n deasserts.
REQ-030 SHALL abandon any in-flight command on reset (no write pulse completes, no response issued), including reset asserted during WRITE, which forces select=1 immediately.

Verification
REQ-031 SHALL cover: write addr 1 data 15 -> select=0 for one cycle, writeAddress=1, writeData=15; rsp_valid, rsp_write=1, rsp_err=0.
REQ-032 SHALL cover: writes 1<-15, 3<-10, then read (1,3) against a 32x16 register-file model with READ_LAT=1 -> rsp_data1=15, rsp_data2=10.
REQ-033 SHALL cover: NUM_REGS=16, read (20,2) -> rsp_err=1, data 0, select stays 1 throughout.
REQ-034 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rsp_data* stable, cmd_ready=0, new cmd_valid ignored.
REQ-035 SHALL cover: rst_n pulsed low mid-WRITE -> select=1 asynchronously, no response, cmd_ready=1 one edge after release.
REQ-036 SHALL cover: READ_LAT=3 -> capture at the third edge after acceptance, addresses stable across all three cycles.
